// File: rtl/grid_lif_filter.sv
// grid_lif_filter: per-cell leaky integrate-and-fire filter behind the
// frame-difference motion detector. After each frame_done the neurons are
// updated serially (one cell per clock), then the fired map, fired count and
// a held/debounced motion alert are published together with update_done.
//
// Optional build macro: GRID_LIF_LATERAL_EN adds a lateral excitation term
// (SPIKE_WEIGHT>>2 per active 4-connected neighbour, no edge wrap). The grid
// is then treated as a sqrt(GRID_CELLS) square, so GRID_CELLS must be a power
// of 4 in that build.
//
// Handshake: frame_done is a one-cycle strobe; grid_activity and
// motion_detected are only sampled with it while idle. A frame_done that
// arrives while busy is dropped and sets the sticky overrun flag.
// update_done pulses for one cycle when the outputs have been refreshed.
module grid_lif_filter #(
   parameter int GRID_CELLS   = 16,
   parameter int V_WIDTH      = 8,
   parameter int SPIKE_WEIGHT = 64,
   parameter int LEAK_SHIFT   = 2,
   parameter int V_THRESH     = 128,
   parameter int MIN_FIRING   = 2,
   parameter int HOLD_FRAMES  = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  frame_done,
   input  logic [GRID_CELLS-1:0]                 grid_activity,
   input  logic                                  motion_detected,
   output logic [GRID_CELLS-1:0]                 fired_map,
   output logic [$clog2(GRID_CELLS+1)-1:0]       fired_count,
   output logic                                  alert,
   output logic                                  update_done,
   output logic                                  busy,
   output logic                                  overrun,
   output logic [1:0]                            dbg_state
);

   localparam int IDX_W = $clog2(GRID_CELLS);
   localparam int CNT_W = $clog2(GRID_CELLS+1);
   // Two spare bits: leak + spike + lateral can reach almost 3 * 2^V_WIDTH.
   localparam int SUM_W = V_WIDTH + 2;

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(GRID_CELLS - 1);
   localparam logic [SUM_W-1:0]   SPIKE_EXT = SUM_W'(SPIKE_WEIGHT);
   localparam logic [SUM_W-1:0]   V_MAX_EXT = SUM_W'({V_WIDTH{1'b1}});
   localparam logic [V_WIDTH-1:0] THRESH_V  = V_WIDTH'(V_THRESH);
   localparam logic [CNT_W-1:0]   MIN_CNT   = CNT_W'(MIN_FIRING);
   localparam logic [7:0]         HOLD_INIT = 8'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DECIDE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [GRID_CELLS-1:0] snap_q;
   logic                  snap_motion_q;
   logic [GRID_CELLS-1:0] next_map_q;
   logic [V_WIDTH-1:0]    v_q [GRID_CELLS];
   logic [GRID_CELLS-1:0] fired_map_q;
   logic [CNT_W-1:0]      fired_count_q;
   logic [7:0]            hold_q, hold_d;
   logic                  alert_q;
   logic                  update_done_q;
   logic                  overrun_q;

   logic [V_WIDTH-1:0]    v_cur;
   logic [SUM_W-1:0]      leak_ext, spike_ext, lat_ext, sum;
   logic [V_WIDTH-1:0]    v_sat, v_new;
   logic                  fire;
   logic [CNT_W-1:0]      pop;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: idle -> serial update of every cell -> decide -> idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (frame_done) state_d = S_UPDATE;
         S_UPDATE: if (idx_q == LAST_IDX) state_d = S_DECIDE;
         S_DECIDE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

`ifdef GRID_LIF_LATERAL_EN
   localparam int               SIDE_LOG = IDX_W / 2;
   localparam logic [IDX_W-1:0] SIDE_IDX = IDX_W'(1 << SIDE_LOG);
   localparam logic [IDX_W-1:0] SIDE_MAX = IDX_W'((1 << SIDE_LOG) - 1);
   localparam logic [SUM_W-1:0] LAT_EXT  = SUM_W'(SPIKE_WEIGHT >> 2);
   logic [IDX_W-1:0] row, col;
`endif

   // Neuron arithmetic for the cell currently addressed by idx_q.
   always_comb begin
      v_cur     = v_q[idx_q];
      leak_ext  = SUM_W'(v_cur - (v_cur >> LEAK_SHIFT));
      spike_ext = snap_q[idx_q] ? SPIKE_EXT : '0;
      lat_ext   = '0;
`ifdef GRID_LIF_LATERAL_EN
      row = idx_q >> SIDE_LOG;
      col = idx_q & SIDE_MAX;
      if ((row != '0) && snap_q[idx_q - SIDE_IDX])       lat_ext = lat_ext + LAT_EXT;
      if ((row != SIDE_MAX) && snap_q[idx_q + SIDE_IDX]) lat_ext = lat_ext + LAT_EXT;
      if ((col != '0) && snap_q[idx_q - IDX_W'(1)])      lat_ext = lat_ext + LAT_EXT;
      if ((col != SIDE_MAX) && snap_q[idx_q + IDX_W'(1)]) lat_ext = lat_ext + LAT_EXT;
`endif
      sum   = leak_ext + spike_ext + lat_ext;
      v_sat = (sum > V_MAX_EXT) ? {V_WIDTH{1'b1}} : sum[V_WIDTH-1:0];
      fire  = (v_sat >= THRESH_V);
      v_new = fire ? '0 : v_sat;
   end

   // Decision: popcount of the new map and the alert hold counter update.
   always_comb begin
      pop = '0;
      for (int i = 0; i < GRID_CELLS; i++) pop = pop + CNT_W'(next_map_q[i]);
      hold_d = hold_q;
      if ((pop >= MIN_CNT) && snap_motion_q) hold_d = HOLD_INIT;
      else if (hold_q != 8'd0)               hold_d = hold_q - 8'd1;
   end

   // Datapath: snapshot, serial neuron write-back, atomic output publish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= '0;
         snap_q        <= '0;
         snap_motion_q <= 1'b0;
         next_map_q    <= '0;
         for (int i = 0; i < GRID_CELLS; i++) v_q[i] <= '0;
         fired_map_q   <= '0;
         fired_count_q <= '0;
         hold_q        <= '0;
         alert_q       <= 1'b0;
         update_done_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         update_done_q <= 1'b0;
         if (frame_done && (state_q != S_IDLE)) overrun_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (frame_done) begin
                  snap_q        <= grid_activity;
                  snap_motion_q <= motion_detected;
                  idx_q         <= '0;
               end
            end
            S_UPDATE: begin
               v_q[idx_q]        <= v_new;
               next_map_q[idx_q] <= fire;
               if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
            end
            S_DECIDE: begin
               fired_map_q   <= next_map_q;
               fired_count_q <= pop;
               hold_q        <= hold_d;
               alert_q       <= (hold_d != 8'd0);
               update_done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fired_map   = fired_map_q;
   assign fired_count = fired_count_q;
   assign alert       = alert_q;
   assign update_done = update_done_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign dbg_state   = state_q;

endmodule
